// File: rtl/vending_machine_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vm_pkg
// Purpose : Shared definitions for the multi-product vending machine.
//           - Coin-code constants.
//           - FSM state encoding.
//           - Coin value lookup.
//           - Greedy coin choice.
//           - Index-width helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package vm_pkg;

  // Coin codes as presented on the acceptor input and the change output
  localparam logic [1:0] COIN_NONE = 2'd0;
  localparam logic [1:0] COIN_5    = 2'd1;  // 1 unit
  localparam logic [1:0] COIN_10   = 2'd2;  // 2 units
  localparam logic [1:0] COIN_20   = 2'd3;  // 4 units

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // credit is zero
    ST_CREDIT = 2'd1,  // credit is non-zero, waiting for a selection
    ST_VEND   = 2'd2,  // one-cycle vend pulse
    ST_CHANGE = 2'd3   // paying out remaining credit, one coin per cycle
  } vm_state_t;

  // Value of a coin code in units of 5
  function automatic logic [2:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_5:  return 3'd1;
      COIN_10: return 3'd2;
      COIN_20: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Largest coin not exceeding the given credit (COIN_NONE when credit is 0).
  // The argument is wide so any credit register width can be passed in.
  function automatic logic [1:0] largest_coin(input logic [31:0] credit);
    if (credit >= 32'd4) begin
      return COIN_20;
    end else if (credit >= 32'd2) begin
      return COIN_10;
    end else if (credit >= 32'd1) begin
      return COIN_5;
    end
    return COIN_NONE;
  endfunction

  // Selection index width; a single-product machine still gets a 1-bit index
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vending_machine_multi_if.sv
`default_nettype none
// ============================================================================
// Module  : vending_machine_multi_if
// Purpose : Bundles the coin/selection inputs and the vend/change/status
//           outputs of the vending machine.
// Ports   :
//   Host to machine:
//     in [1:0]         coin code (0 none, 1 = 5, 2 = 10, 3 = 20)
//     sel_valid        selection strobe
//     sel_idx          selected product
//     cancel           refund request
//   Machine to host:
//     out              vend pulse
//     item             vended index
//     change [1:0]     returned coin code
//     reject           refused-coin pulse
//     credit           current credit in units
//     busy             vending or paying change
// Modports: master (host / acceptor side), slave (machine side)
// Revision: 1.0 - initial release
// ============================================================================
interface vending_machine_multi_if #(
  parameter int NUM_ITEMS = 4,
  parameter int CREDIT_W  = 6
);
  localparam int IDX_W = vm_pkg::idx_width(NUM_ITEMS);

  logic [1:0]          in;
  logic                sel_valid;
  logic [IDX_W-1:0]    sel_idx;
  logic                cancel;
  logic                out;
  logic [IDX_W-1:0]    item;
  logic [1:0]          change;
  logic                reject;
  logic [CREDIT_W-1:0] credit;
  logic                busy;

  modport master (
    output in, sel_valid, sel_idx, cancel,
    input  out, item, change, reject, credit, busy
  );

  modport slave (
    input  in, sel_valid, sel_idx, cancel,
    output out, item, change, reject, credit, busy
  );

endinterface
`default_nettype wire

// File: rtl/vending_machine_multi_dispenser.sv
`default_nettype none
// ============================================================================
// Module  : vm_change_dispenser
// Purpose : Greedy change step. Given the remaining credit, it picks the
//           largest coin that fits and returns the credit left after paying
//           it. Purely combinational. A zero credit yields COIN_NONE with the
//           credit unchanged.
// Ports   :
//   credit       remaining credit (units)
//   coin         coin code to pay out this cycle
//   credit_next  credit after paying that coin
// Revision: 1.0 - initial release
// ============================================================================
module vm_change_dispenser
  import vm_pkg::*;
#(
  parameter int CREDIT_W = 6
) (
  input  logic [CREDIT_W-1:0] credit,
  output logic [1:0]          coin,
  output logic [CREDIT_W-1:0] credit_next
);

  assign coin        = largest_coin(32'(credit));
  assign credit_next = credit - CREDIT_W'(coin_value(coin));

endmodule
`default_nettype wire

// File: rtl/vending_machine_multi.sv
`default_nettype none
// ============================================================================
// Module  : vending_machine_multi
// Purpose : Multi-product vending machine.
//           - Accumulates coin credit up to MAX_CREDIT.
//           - Vends one of NUM_ITEMS individually priced products.
//           - Returns change greedily, one coin per cycle.
//           - All outputs are registered.
// Ports   :
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   vending_machine_multi_if.slave
//         (coin / selection inputs, vend / change / status outputs)
// Config  : VM_REFUND_EN - when defined, cancel in CREDIT refunds the full
//           credit through the change path. Otherwise cancel is ignored.
// Revision: 1.0 - initial release
// ============================================================================
module vending_machine_multi
  import vm_pkg::*;
#(
  parameter int                            NUM_ITEMS  = 4,
  parameter int                            CREDIT_W   = 6,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES     = {6'd4, 6'd3, 6'd2, 6'd6},
  parameter int                            MAX_CREDIT = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  vending_machine_multi_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_ITEMS);

`ifdef VM_REFUND_EN
  localparam bit REFUND_EN = 1'b1;
`else
  localparam bit REFUND_EN = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Registers and their next values
  // --------------------------------------------------------------------------
  vm_state_t           state, state_nxt;
  logic [CREDIT_W-1:0] credit_reg, credit_nxt;
  logic                out_reg, out_nxt;
  logic [IDX_W-1:0]    item_reg, item_nxt;
  logic [1:0]          change_reg, change_nxt;
  logic                reject_reg, reject_nxt;
  logic                busy_reg, busy_nxt;

  // --------------------------------------------------------------------------
  // Input decode
  // --------------------------------------------------------------------------
  logic [CREDIT_W-1:0] price_tbl [NUM_ITEMS];

  for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_price
    assign price_tbl[i] = PRICES[i*CREDIT_W +: CREDIT_W];
  end

  logic                coin_in;
  logic [CREDIT_W:0]   credit_sum;  // one spare bit so the limit check never wraps
  logic                coin_fits;
  logic                idx_ok;
  logic [CREDIT_W-1:0] price;
  logic                can_buy;
  logic                cancel_req;

  assign coin_in    = (bus.in != COIN_NONE);
  assign credit_sum = {1'b0, credit_reg} + (CREDIT_W+1)'(coin_value(bus.in));
  assign coin_fits  = (credit_sum <= (CREDIT_W+1)'(MAX_CREDIT));
  assign idx_ok     = (int'(bus.sel_idx) < NUM_ITEMS);
  assign price      = idx_ok ? price_tbl[bus.sel_idx] : '0;

  // A coin in the same cycle wins over the selection; the host re-asserts it
  assign can_buy    = bus.sel_valid && idx_ok && !coin_in && (credit_reg >= price);

  // Refund only exists in CREDIT; it outranks coins and selections
  assign cancel_req = REFUND_EN && bus.cancel && (state == ST_CREDIT);

  // Greedy change step, shared by VEND, CHANGE and the refund entry
  logic [1:0]          disp_coin;
  logic [CREDIT_W-1:0] disp_credit;

  vm_change_dispenser #(
    .CREDIT_W (CREDIT_W)
  ) u_change_dispenser (
    .credit      (credit_reg),
    .coin        (disp_coin),
    .credit_next (disp_credit)
  );

  // --------------------------------------------------------------------------
  // State register (outputs are registered alongside the state)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      credit_reg <= '0;
      out_reg    <= 1'b0;
      item_reg   <= '0;
      change_reg <= COIN_NONE;
      reject_reg <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state      <= state_nxt;
      credit_reg <= credit_nxt;
      out_reg    <= out_nxt;
      item_reg   <= item_nxt;
      change_reg <= change_nxt;
      reject_reg <= reject_nxt;
      busy_reg   <= busy_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_CREDIT: begin
        if (cancel_req) begin
          state_nxt = ST_CHANGE;
        end else if (coin_in) begin
          if (coin_fits) begin
            state_nxt = ST_CREDIT;
          end
        end else if (can_buy) begin
          state_nxt = ST_VEND;
        end
      end
      // Stay in CHANGE while credit remains to be paid. Credit already shows
      // the value left after the coin currently on the change output.
      ST_VEND, ST_CHANGE: begin
        state_nxt = (credit_reg != '0) ? ST_CHANGE : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    credit_nxt = credit_reg;
    out_nxt    = 1'b0;
    item_nxt   = '0;
    change_nxt = COIN_NONE;
    reject_nxt = 1'b0;
    case (state)
      ST_IDLE, ST_CREDIT: begin
        if (cancel_req) begin
          credit_nxt = disp_credit;
          change_nxt = disp_coin;
          reject_nxt = coin_in;
        end else if (coin_in) begin
          if (coin_fits) begin
            credit_nxt = credit_sum[CREDIT_W-1:0];
          end else begin
            reject_nxt = 1'b1;
          end
        end else if (can_buy) begin
          credit_nxt = credit_reg - price;
          out_nxt    = 1'b1;
          item_nxt   = bus.sel_idx;
        end
      end
      ST_VEND, ST_CHANGE: begin
        reject_nxt = coin_in;
        if (credit_reg != '0) begin
          credit_nxt = disp_credit;
          change_nxt = disp_coin;
        end
      end
      default: ;
    endcase
    busy_nxt = (state_nxt == ST_VEND) || (state_nxt == ST_CHANGE);
  end

  assign bus.out    = out_reg;
  assign bus.item   = item_reg;
  assign bus.change = change_reg;
  assign bus.reject = reject_reg;
  assign bus.credit = credit_reg;
  assign bus.busy   = busy_reg;

endmodule
`default_nettype wire

// File: tb/tb_vending_machine_multi.sv
`default_nettype none
// ============================================================================
// Module  : tb_vending_machine_multi
// Purpose : Self-checking bench for vending_machine_multi.
//           - Inputs are driven on the falling edge.
//           - The expected outputs for each cycle are queued as the inputs
//             are driven.
//           - Those expected outputs are popped and compared on the next
//             falling edge.
//           - The refund expectations follow VM_REFUND_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vending_machine_multi;
  import vm_pkg::*;

  localparam int NUM_ITEMS  = 4;
  localparam int CREDIT_W   = 6;
  localparam int MAX_CREDIT = 12;
  // Item 0 sits in the low bits: idx0 = 4, idx1 = 2, idx2 = 3, idx3 = 6 units
  localparam logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {6'd6, 6'd3, 6'd2, 6'd4};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vending_machine_multi_if #(.NUM_ITEMS(NUM_ITEMS), .CREDIT_W(CREDIT_W)) vif ();

  vending_machine_multi #(
    .NUM_ITEMS  (NUM_ITEMS),
    .CREDIT_W   (CREDIT_W),
    .PRICES     (PRICES),
    .MAX_CREDIT (MAX_CREDIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif.slave)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic [1:0] coin;
    logic       sel;
    logic [1:0] idx;
    logic       cancel;
    logic       out;
    logic [1:0] item;
    logic [1:0] change;
    logic       reject;
    logic [5:0] credit;
    logic       busy;
  } vec_t;

  vec_t vecs[$];
  vec_t expq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(string name, int r, int coin, int sel, int idx, int cancel,
                              int out, int item, int change, int reject, int credit, int busy);
    vec_t v;
    v.name   = name;
    v.rst    = 1'(r);
    v.coin   = 2'(coin);
    v.sel    = 1'(sel);
    v.idx    = 2'(idx);
    v.cancel = 1'(cancel);
    v.out    = 1'(out);
    v.item   = 2'(item);
    v.change = 2'(change);
    v.reject = 1'(reject);
    v.credit = 6'(credit);
    v.busy   = 1'(busy);
    return v;
  endfunction

  task automatic check_out();
    vec_t        e;
    logic [12:0] got;
    logic [12:0] want;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: output cycle with no expected entry queued");
      return;
    end
    e    = expq.pop_front();
    got  = {vif.out, vif.item, vif.change, vif.reject, vif.credit, vif.busy};
    want = {e.out, e.item, e.change, e.reject, e.credit, e.busy};
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got out=%b item=%0d change=%0d reject=%b credit=%0d busy=%b, want out=%b item=%0d change=%0d reject=%b credit=%0d busy=%b",
               e.name, vif.out, vif.item, vif.change, vif.reject, vif.credit, vif.busy,
               e.out, e.item, e.change, e.reject, e.credit, e.busy);
    end
  endtask

  // Drive one cycle of inputs, queue the outputs expected after the edge,
  // then compare them on the following falling edge.
  task automatic step(input vec_t v);
    rst           = v.rst;
    vif.in        = v.coin;
    vif.sel_valid = v.sel;
    vif.sel_idx   = v.idx;
    vif.cancel    = v.cancel;
    expq.push_back(v);
    @(negedge clk);
    check_out();
  endtask

  task automatic s(string name, int r, int coin, int sel, int idx, int cancel,
                   int out, int item, int change, int reject, int credit, int busy);
    step(mk(name, r, coin, sel, idx, cancel, out, item, change, reject, credit, busy));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin : stimulus
    vif.in        = COIN_NONE;
    vif.sel_valid = 1'b0;
    vif.sel_idx   = '0;
    vif.cancel    = 1'b0;

    //                   name           rst in sv ix cn  out it ch rj cr bz
    vecs.push_back(mk("reset",          1, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0));
    vecs.push_back(mk("exact_coin_a",   0, 2, 0, 0, 0,  0, 0, 0, 0,  2, 0));
    vecs.push_back(mk("exact_coin_b",   0, 2, 0, 0, 0,  0, 0, 0, 0,  4, 0));
    vecs.push_back(mk("exact_vend",     0, 0, 1, 0, 0,  1, 0, 0, 0,  0, 1));
    vecs.push_back(mk("exact_idle",     0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0));
    vecs.push_back(mk("chg_coin_a",     0, 2, 0, 0, 0,  0, 0, 0, 0,  2, 0));
    vecs.push_back(mk("chg_coin_b",     0, 2, 0, 0, 0,  0, 0, 0, 0,  4, 0));
    vecs.push_back(mk("chg_coin_c",     0, 2, 0, 0, 0,  0, 0, 0, 0,  6, 0));
    vecs.push_back(mk("chg_vend",       0, 0, 1, 0, 0,  1, 0, 0, 0,  2, 1));
    vecs.push_back(mk("chg_pay10",      0, 0, 0, 0, 0,  0, 0, 2, 0,  0, 1));
    vecs.push_back(mk("chg_idle",       0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0));
    vecs.push_back(mk("low_coin",       0, 1, 0, 0, 0,  0, 0, 0, 0,  1, 0));
    vecs.push_back(mk("low_sel3",       0, 0, 1, 3, 0,  0, 0, 0, 0,  1, 0));
    vecs.push_back(mk("coin_with_sel",  0, 3, 1, 0, 0,  0, 0, 0, 0,  5, 0));
    vecs.push_back(mk("coin_beats_sel", 0, 1, 1, 1, 0,  0, 0, 0, 0,  6, 0));
    vecs.push_back(mk("sel1_vend",      0, 0, 1, 1, 0,  1, 1, 0, 0,  4, 1));
    vecs.push_back(mk("coin_in_vend",   0, 2, 0, 0, 0,  0, 0, 3, 1,  0, 1));
    vecs.push_back(mk("sel1_idle",      0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0));
    vecs.push_back(mk("ovf_fill_4",     0, 3, 0, 0, 0,  0, 0, 0, 0,  4, 0));
    vecs.push_back(mk("ovf_fill_8",     0, 3, 0, 0, 0,  0, 0, 0, 0,  8, 0));
    vecs.push_back(mk("ovf_fill_12",    0, 3, 0, 0, 0,  0, 0, 0, 0, 12, 0));
    vecs.push_back(mk("ovf_reject",     0, 1, 0, 0, 0,  0, 0, 0, 1, 12, 0));
    vecs.push_back(mk("ovf_hold",       0, 0, 0, 0, 0,  0, 0, 0, 0, 12, 0));
    vecs.push_back(mk("busy_vend",      0, 0, 1, 0, 0,  1, 0, 0, 0,  8, 1));
    vecs.push_back(mk("busy_pay20",     0, 0, 0, 0, 0,  0, 0, 3, 0,  4, 1));
    vecs.push_back(mk("busy_coin",      0, 3, 0, 0, 0,  0, 0, 3, 1,  0, 1));
    vecs.push_back(mk("busy_idle",      0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i]);
    end

    // Reset while change is being paid: everything clears, nothing more is paid
    s("rmc_fill_4",   0, 3, 0, 0, 0,  0, 0, 0, 0,  4, 0);
    s("rmc_fill_8",   0, 3, 0, 0, 0,  0, 0, 0, 0,  8, 0);
    s("rmc_fill_12",  0, 3, 0, 0, 0,  0, 0, 0, 0, 12, 0);
    s("rmc_vend",     0, 0, 1, 1, 0,  1, 1, 0, 0, 10, 1);
    s("rmc_pay20",    0, 0, 0, 0, 0,  0, 0, 3, 0,  6, 1);
    s("rmc_reset",    1, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0);
    s("rmc_quiet",    0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0);
    s("rmc_recover",  0, 1, 0, 0, 0,  0, 0, 0, 0,  1, 0);

`ifdef VM_REFUND_EN
    // Cancel outranks the coin in the same cycle; the coin is refused
    s("rf_coin_cancel", 0, 2, 0, 0, 1,  0, 0, 1, 1,  0, 1);
    s("rf_coin_idle",   0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0);
    s("rf_fill_4",      0, 3, 0, 0, 0,  0, 0, 0, 0,  4, 0);
    s("rf_fill_6",      0, 2, 0, 0, 0,  0, 0, 0, 0,  6, 0);
    s("rf_fill_7",      0, 1, 0, 0, 0,  0, 0, 0, 0,  7, 0);
    s("rf_pay20",       0, 0, 1, 0, 1,  0, 0, 3, 0,  3, 1);
    s("rf_pay10",       0, 0, 0, 0, 0,  0, 0, 2, 0,  1, 1);
    s("rf_pay5",        0, 0, 0, 0, 0,  0, 0, 1, 0,  0, 1);
    s("rf_idle",        0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0);
    s("rfr_fill_4",     0, 3, 0, 0, 0,  0, 0, 0, 0,  4, 0);
    s("rfr_fill_6",     0, 2, 0, 0, 0,  0, 0, 0, 0,  6, 0);
    s("rfr_fill_7",     0, 1, 0, 0, 0,  0, 0, 0, 0,  7, 0);
    s("rfr_pay20",      0, 0, 0, 0, 1,  0, 0, 3, 0,  3, 1);
    s("rfr_reset",      1, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0);
`else
    // Without refund support cancel changes nothing
    s("nc_coin_cancel", 0, 2, 0, 0, 1,  0, 0, 0, 0,  3, 0);
    s("nc_cancel",      0, 0, 0, 0, 1,  0, 0, 0, 0,  3, 0);
    s("nc_fill_7",      0, 3, 0, 0, 0,  0, 0, 0, 0,  7, 0);
    s("nc_cancel_b",    0, 0, 0, 0, 1,  0, 0, 0, 0,  7, 0);
    s("nc_fill_8",      0, 1, 0, 0, 0,  0, 0, 0, 0,  8, 0);
    s("nc_vend3",       0, 0, 1, 3, 0,  1, 3, 0, 0,  2, 1);
    s("nc_pay10",       0, 0, 0, 0, 0,  0, 0, 2, 0,  0, 1);
    s("nc_idle",        0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0);
`endif
    // Cancel in IDLE is ignored in either build
    s("idle_cancel",    0, 0, 0, 0, 1,  0, 0, 0, 0,  0, 0);
    s("idle_quiet",     0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
